// File: rtl/nasti_wrr_arb.sv
// nasti_wrr_arb
//   Weighted round-robin scheduler for one NASTI address channel (AW or AR)
//   shared by up to N slave ports. Each requester may take weight+1
//   consecutive grants before priority rotates to the next port. A grant is
//   registered and held until ack (address handshake, or last write beat when
//   write-locked) or until the granted requester withdraws its request.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   req        in   [N]     request vector, bit i = port i has a valid address
//   weight     in   [N*WW]  per-port weight, field i = weight[i*WW +: WW]
//   enable     in   permits new grants (does not affect a held grant)
//   ack        in   current grant consumed, single-cycle pulse
//   gnt        out  [N]     one-hot registered grant
//   gnt_valid  out  OR of gnt
//   gnt_idx    out  [IW]    binary index of the granted port, 0 when idle
module nasti_wrr_arb #(
  parameter  int N  = 8,
  parameter  int WW = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] weight,
  input  logic            enable,
  input  logic            ack,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [IW-1:0]   gnt_idx
);

  localparam logic [0:0] ARB   = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    r_state;
  logic [N-1:0]  r_gnt;
  logic [IW-1:0] r_win;
  logic [IW-1:0] r_ptr;
  logic [WW:0]   r_cnt;

  logic          w_found;
  logic [IW-1:0] w_idx;
  logic [WW-1:0] w_wsel;
  logic [WW:0]   w_cnt_n;
  logic [IW-1:0] w_ptr_next;

  // (a + k) mod N for k in 0..N-1; N need not be a power of two.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int k);
    int s;
    s = k + int'(a);
    if (s >= N) s = s - N;
    return s[IW-1:0];
  endfunction

  // Search requests starting at the priority pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && req[wrap_add(r_ptr, k)]) begin
        w_found = 1'b1;
        w_idx   = wrap_add(r_ptr, k);
      end
    end
  end

  // Weight is only looked at on the ack cycle, so mid-grant changes take
  // effect at the next ack. cnt is one bit wider than the weight, so an
  // all-ones weight (2^WW grants) never overflows.
  assign w_wsel     = weight[r_win*WW +: WW];
  assign w_cnt_n    = r_cnt + (WW+1)'(1);
  assign w_ptr_next = (r_win == IW'(N-1)) ? '0 : r_win + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB;
      r_gnt   <= '0;
      r_win   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ARB: begin
          if (enable && w_found) begin
            r_gnt   <= {{(N-1){1'b0}}, 1'b1} << w_idx;
            r_win   <= w_idx;
            r_state <= GRANT;
            // A different owner starts a fresh quota.
            if (w_idx != r_ptr) begin
              r_ptr <= w_idx;
              r_cnt <= '0;
            end
          end
        end
        GRANT: begin
          // ack takes precedence over a simultaneous withdrawal.
          if (ack) begin
            if (w_cnt_n > {1'b0, w_wsel}) begin
              r_ptr <= w_ptr_next;
              r_cnt <= '0;
            end else begin
              r_cnt <= w_cnt_n;
            end
            r_gnt   <= '0;
            r_state <= ARB;
          end else if (!req[r_win]) begin
            // Withdrawn request: drop the grant, no quota consumed.
            r_gnt   <= '0;
            r_state <= ARB;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_state <= ARB;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = |r_gnt;
  assign gnt_idx   = (r_state == GRANT) ? r_win : '0;

endmodule
